// File: rtl/lcd_char_writer.sv
// lcd_char_writer
//   Writes single characters to an HD44780-style character LCD once the
//   external init sequence has finished. Each accepted request drives a
//   set-DDRAM-address command followed by a data write, each with an EN
//   pulse and a command settle delay.
//
//   Optional feature macro: LCD_CURSOR_TRACK_EN
//     When defined, the block tracks the LCD's auto-incrementing cursor. A
//     write to the position the cursor already points at skips the
//     set-address command.
//
// Ports
//   CLK        board clock; every register updates on its rising edge
//   RST        asynchronous active-high reset
//   init_done  high once the LCD power-on init sequence has finished
//   wr_valid   character write request
//   wr_addr    [4] line, [3:0] column
//   wr_data    character code
//   wr_ready   request accepted this cycle when wr_valid is also high
//   dOut       LCD data bus
//   ctrl       {EN, RW, RS}; RW is always 0
//   busy       a command is in progress
module lcd_char_writer #(
  parameter int CLKS_PER_US = 50,
  parameter int EN_US       = 1,
  parameter int CMD_US      = 40
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       init_done,
  input  logic       wr_valid,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic [7:0] dOut,
  output logic [2:0] ctrl,
  output logic       busy
);

  // Counter reloads are "cycles - 1" because the load cycle itself counts.
  localparam logic [15:0] EN_LD  = 16'(CLKS_PER_US * EN_US - 1);
  localparam logic [15:0] CMD_LD = 16'(CLKS_PER_US * CMD_US - 1);

  typedef enum logic [2:0] {
    IDLE, READY, SET_ADDR, ADDR_DLY, WR_CHAR, CHAR_DLY
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        xfer;
  logic        skip;
  logic        cnt_zero;

  // Ready is withheld when init_done has dropped so a request is never
  // accepted in the cycle the FSM falls back to IDLE.
  assign wr_ready = (state_q == READY) && init_done;
  assign xfer     = wr_valid && wr_ready;
  assign cnt_zero = (cnt_q == 16'd0);
  assign busy     = (state_q != IDLE) && (state_q != READY);

`ifdef LCD_CURSOR_TRACK_EN
  logic [4:0] cur_q, cur_d;
  logic       cur_vld_q, cur_vld_d;

  assign skip = cur_vld_q && (wr_addr == cur_q);

  always_comb begin
    cur_d     = cur_q;
    cur_vld_d = cur_vld_q;
    if (xfer && !skip) begin
      cur_d     = wr_addr;
      cur_vld_d = 1'b1;
    end else if (state_q == WR_CHAR && cnt_zero) begin
      // The LCD does not wrap col 15 to the next line, so position is lost.
      if (cur_q[3:0] == 4'hF) cur_vld_d = 1'b0;
      else                    cur_d[3:0] = cur_q[3:0] + 4'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cur_q     <= '0;
      cur_vld_q <= 1'b0;
    end else begin
      cur_q     <= cur_d;
      cur_vld_q <= cur_vld_d;
    end
  end
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (init_done) state_d = READY;
      READY: begin
        if (!init_done) begin
          state_d = IDLE;
        end else if (xfer) begin
          addr_d  = wr_addr;
          data_d  = wr_data;
          cnt_d   = EN_LD;
          state_d = skip ? WR_CHAR : SET_ADDR;
        end
      end
      SET_ADDR: begin
        if (cnt_zero) begin
          state_d = ADDR_DLY;
          cnt_d   = CMD_LD;
        end else cnt_d = cnt_q - 16'd1;
      end
      ADDR_DLY: begin
        if (cnt_zero) begin
          state_d = WR_CHAR;
          cnt_d   = EN_LD;
        end else cnt_d = cnt_q - 16'd1;
      end
      WR_CHAR: begin
        if (cnt_zero) begin
          state_d = CHAR_DLY;
          cnt_d   = CMD_LD;
        end else cnt_d = cnt_q - 16'd1;
      end
      CHAR_DLY: begin
        if (cnt_zero) state_d = init_done ? READY : IDLE;
        else          cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Outputs decode straight from state so reset clears them asynchronously.
  always_comb begin
    dOut = 8'h00;
    ctrl = 3'b000;
    case (state_q)
      SET_ADDR, ADDR_DLY: begin
        dOut    = {1'b1, addr_q[4], 2'b00, addr_q[3:0]};
        ctrl[2] = (state_q == SET_ADDR);
      end
      WR_CHAR, CHAR_DLY: begin
        dOut    = data_q;
        ctrl[0] = 1'b1;
        ctrl[2] = (state_q == WR_CHAR);
      end
      default: ;
    endcase
  end

endmodule
